// File: rtl/lsu_pkg.sv
// Shared width codes, FSM encoding and request legality check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_WRITE  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic lsu_is_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic misal;
        if (we)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        misal = ((f3[1:0] == 2'b01) && a[0]) ||
                ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misal;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extract + sign/zero extend, and SB/SH lane merge.
// Zero latency; no flow control.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_word;
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = '0;
        endcase

        // Only SB/SH reach the merge path, so the size bits alone pick the lane width.
        o_merged = i_word;
        if (i_funct3[1:0] == 2'b01)
            o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
        else
            o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
    end

endmodule

// File: rtl/load_store_unit.sv
// Word-aligned load/store engine with read-modify-write for SB/SH; LW 3, SW 2, SB/SH 4, ERR 1 cycles.
// One request in flight: req_ready only in IDLE, resp_valid is a single pulse with no backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] C_RD_LAST = 2'(READ_LATENCY);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [1:0]  r_cnt;
    logic [31:0] r_rd_word;

    logic        w_accept;
    logic        w_req_err;
    logic        w_rd_last;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_err = lsu_is_err(req_we, req_funct3, req_addr[1:0]);
    assign w_rd_last = (r_cnt == C_RD_LAST);
    assign mem_addr  = {r_addr[31:2], 2'b00};

    lsu_lane_align u_align (
        .i_word      (r_rd_word),
        .i_addr_lo   (r_addr[1:0]),
        .i_funct3    (r_funct3),
        .i_wdata     (r_wdata[15:0]),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_req_err)
                        w_next = S_RESP;
                    else if (!req_we)
                        w_next = S_READ;
                    else if (req_funct3 == F3_W)
                        w_next = S_WRITE;
                    else
                        w_next = S_RMW_RD;
                end
            end
            S_READ: begin
                if (w_rd_last)
                    w_next = S_RESP;
            end
            S_RMW_RD: begin
                if (w_rd_last)
                    w_next = S_RMW_WR;
            end
            // A reset landing on a write cycle must not let the write through.
            S_RMW_WR: begin
                mem_we = !rst;
                mem_wd = w_merged;
                w_next = S_RESP;
            end
            S_WRITE: begin
                mem_we = !rst;
                mem_wd = r_wdata;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = !rst;
                resp_err   = r_err;
                resp_rdata = (r_we || r_err) ? 32'h0 : w_load_data;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_rd_word <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_req_err;
            r_cnt    <= '0;
        end else if ((r_state == S_READ) || (r_state == S_RMW_RD)) begin
            if (w_rd_last)
                r_rd_word <= mem_rd;
            else
                r_cnt <= r_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + random bench for load_store_unit against a byte-level memory reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.READ_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Memory device with one cycle of read latency and no byte enables.
    logic [31:0] dut_mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_we) dut_mem[mem_addr[7:2]] <= mem_wd;
        mem_rd <= dut_mem[mem_addr[7:2]];
    end

    int          we_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;
    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wd;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    logic [31:0] ref_mem [64] = '{default: 32'h0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: legality, latency and data computed from sizes and byte shifts.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr, output logic [31:0] wword);
        int          nbytes;
        int          sh;
        logic        legal;
        logic [31:0] old;
        logic [31:0] v;
        logic [31:0] mask;
        legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nbytes = 1 << f3[1:0];
        err    = !legal || ((int'(addr[1:0]) % nbytes) != 0);
        old    = ref_mem[addr[7:2]];
        sh     = 8 * int'(addr[1:0]);
        rdata  = 32'h0;
        lat    = 1;
        nwr    = 0;
        wword  = 32'h0;
        if (err) return;
        if (!we) begin
            lat = 3;
            v   = old >> sh;
            if (nbytes == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end else if (nbytes == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            rdata = v;
        end else begin
            nwr = 1;
            if (nbytes == 4) begin
                lat   = 2;
                wword = wd;
            end else begin
                lat   = 4;
                mask  = ((32'd1 << (8 * nbytes)) - 32'd1) << sh;
                wword = (old & ~mask) | ((wd << sh) & mask);
            end
            ref_mem[addr[7:2]] = wword;
        end
    endtask

    task automatic wait_ready(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, 32'(ok), 32'h1);
    endtask

    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got_rd);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] e_ww;
        int          e_lat;
        int          e_nwr;
        int          we0;
        int          lat;
        logic        got;
        logic        g_err;
        model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nwr, e_ww);
        wait_ready(tag);
        we0        = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        got    = 1'b0;
        lat    = 0;
        got_rd = 32'h0;
        g_err  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid  = 1'b0;
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            if (resp_valid) begin
                got    = 1'b1;
                lat    = i;
                got_rd = resp_rdata;
                g_err  = resp_err;
                break;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'h1);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_err"}, 32'(g_err), 32'(e_err));
        check({tag, "_rdata"}, got_rd, e_rd);
        check({tag, "_mem_we_pulses"}, we_cnt - we0, e_nwr);
        if (e_nwr == 1) begin
            check({tag, "_wr_addr"}, last_wa, {addr[31:2], 2'b00});
            check({tag, "_wr_data"}, last_wd, e_ww);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          we0;
        int          rv0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);

        run_op("t1_sw", 1'b1, 3'b010, 32'h00100004, 32'hDEADBEEF, rd);
        run_op("t1_lw", 1'b0, 3'b010, 32'h00100004, 32'h0, rd);
        check("t1_lw_value", rd, 32'hDEADBEEF);

        run_op("t2_sw", 1'b1, 3'b010, 32'h00100004, 32'h11223344, rd);
        run_op("t2_sb", 1'b1, 3'b000, 32'h00100006, 32'h000000A5, rd);
        check("t2_sb_word", last_wd, 32'h11A53344);
        run_op("t2_lb", 1'b0, 3'b000, 32'h00100006, 32'h0, rd);
        check("t2_lb_value", rd, 32'hFFFFFFA5);

        run_op("t3_sw", 1'b1, 3'b010, 32'h00100000, 32'h80017FFF, rd);
        run_op("t3_lh", 1'b0, 3'b001, 32'h00100002, 32'h0, rd);
        check("t3_lh_value", rd, 32'hFFFF8001);
        run_op("t3_lhu", 1'b0, 3'b101, 32'h00100002, 32'h0, rd);
        check("t3_lhu_value", rd, 32'h00008001);

        run_op("t4_lw_mis", 1'b0, 3'b010, 32'h00100001, 32'h0, rd);
        run_op("t4_sh_mis", 1'b1, 3'b001, 32'h00100003, 32'h0000BEEF, rd);
        run_op("t5_ld_011", 1'b0, 3'b011, 32'h00100000, 32'h0, rd);
        run_op("t5_st_100", 1'b1, 3'b100, 32'h00100000, 32'h12345678, rd);

        // Reset lands while the SB is in its read phase; the word must stay untouched.
        run_op("t6_pre_sw", 1'b1, 3'b010, 32'h00100008, 32'hCAFEF00D, rd);
        wait_ready("t6_sb");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h00100009;
        req_wdata  = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        we0       = we_cnt;
        rv0       = rv_cnt;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_idle_after_rst", 32'(req_ready), 32'h1);
        repeat (4) @(negedge clk);
        check("t6_no_write", we_cnt - we0, 0);
        check("t6_no_resp", rv_cnt - rv0, 0);
        run_op("t6_lw", 1'b0, 3'b010, 32'h00100008, 32'h0, rd);
        check("t6_lw_value", rd, 32'hCAFEF00D);

        for (int n = 0; n < 60; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = 32'h00100000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            run_op($sformatf("rnd%0d", n), r_we, r_f3, r_addr, $urandom, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
